// File: rtl/divider_restoring_26b_pkg.sv
// Shared definitions for the 26-bit restoring divider: FSM encoding,
// default operand width and the iteration-counter width helper.
package divider_restoring_26b_pkg;

  // Divisor / quotient / remainder width; the dividend is twice as wide.
  localparam int DIV_WIDTH = 26;

  // Controller states. The encoding is fixed so external checkers can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Width of the down-counter that walks WIDTH-1 .. 0.
  function automatic int div_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/divider_restoring_26b_step.sv
// One restoring-division iteration: shift the partial remainder left by one,
// bring in the next dividend bit, and subtract the divisor if it fits.
module divider_step #(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_r,
  output logic             o_qbit
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_d;
  logic [WIDTH:0] w_diff;

  assign w_t    = {i_r[WIDTH-1:0], i_q_msb};
  assign w_d    = {1'b0, i_divisor};
  assign w_diff = w_t - w_d;

  // A set R msb would be shifted out and means the shifted value certainly
  // exceeds the divisor. The top keeps R < divisor so it is normally zero.
  assign o_qbit = i_r[WIDTH] | (w_t >= w_d);
  assign o_r    = o_qbit ? w_diff : w_t;

endmodule

// File: rtl/divider_restoring_26b.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
//
// Handshake: start is accepted only on a rising edge where busy=0 (state IDLE);
// dividend and divisor are sampled on that edge. busy stays high through CALC
// and DONE, and start is ignored (not queued) while busy. done is a one-cycle
// pulse in DONE; quotient, remainder and flags are valid from that cycle and
// held until the next accept. The FSM state lives in r_state for observation.
module divider_restoring_26b
  import divider_restoring_26b_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_err_zero;
  logic             w_err_ovf;
  logic [WIDTH:0]   w_r_next;
  logic             w_qbit;

  // Error conditions evaluated on the incoming operands at the accept edge.
  // A dividend high half >= divisor would need more than WIDTH quotient bits.
  assign w_err_zero = (divisor == '0);
  assign w_err_ovf  = (dividend[2*WIDTH-1:WIDTH] >= divisor);

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r      (r_r),
    .i_q_msb  (r_q[WIDTH-1]),
    .i_divisor(r_divisor),
    .o_r      (w_r_next),
    .o_qbit   (w_qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; errors skip CALC and report on the following cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_err_zero || w_err_ovf) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (r_cnt == '0) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch, iteration datapath and result registers. Results change
  // only on the error accept or on the final iteration, never mid-operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_r       <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= divisor;
      r_r       <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
      r_q       <= dividend[WIDTH-1:0];
      r_cnt     <= CNT_W'(WIDTH - 1);
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
      if (w_err_zero) begin
        r_dbz  <= 1'b1;
        r_quot <= '1;
        r_rem  <= '0;
      end else if (w_err_ovf) begin
        r_ovf  <= 1'b1;
        r_quot <= '1;
        r_rem  <= '0;
      end
    end else if (r_state == ST_CALC) begin
      r_r   <= w_r_next;
      r_q   <= {r_q[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_quot <= {r_q[WIDTH-2:0], w_qbit};
        r_rem  <= w_r_next[WIDTH-1:0];
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_divider_restoring_26b.sv
// Directed testbench for divider_restoring_26b: hand-computed vectors for
// normal division, error cases, latency, busy handling and mid-op reset.
module tb_divider_restoring_26b;

  localparam int W = 26;

  logic            clk;
  logic            rst;
  logic            start;
  logic [2*W-1:0]  dividend;
  logic [W-1:0]    divisor;
  logic            busy;
  logic            done;
  logic [W-1:0]    quotient;
  logic [W-1:0]    remainder;
  logic            div_by_zero;
  logic            overflow;

  int checks   = 0;
  int failures = 0;

  divider_restoring_26b dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands and raise start before the next accept edge.
  task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
  endtask

  // Count edges (sampled 1 time unit after each) until done, bounded.
  task automatic wait_done(input int c0, input bit drop_start, output int cyc);
    cyc = c0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop_start) start = 1'b0;
    end while (done !== 1'b1 && cyc < 80);
  endtask

  // Check results in the done cycle, then step past DONE into IDLE.
  task automatic check_result(input string tag, input int cyc, input int exp_cyc,
                              input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                              input logic exp_dbz, input logic exp_ovf);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_quot"}, 64'(quotient), 64'(exp_q));
    check({tag, "_rem"}, 64'(remainder), 64'(exp_r));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_held_quot"}, 64'(quotient), 64'(exp_q));
  endtask

  int cyc;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quot", 64'(quotient), 64'd0);
    check("reset_rem", 64'(remainder), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 3000 / 3 = 1000 r 0, done 27 clocks after start.
    issue(52'd3000, 26'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t1_busy_calc", 64'(busy), 64'd1);
    wait_done(1, 1'b1, cyc);
    check_result("t1", cyc, 27, 26'd1000, 26'd0, 1'b0, 1'b0);

    // 2: (2^26-1)^2 / (2^26-1).
    issue(52'hFFFFFF8000001, 26'h3FFFFFF);
    wait_done(0, 1'b1, cyc);
    check_result("t2", cyc, 27, 26'h3FFFFFF, 26'd0, 1'b0, 1'b0);

    // 3: 100 / 7 = 14 r 2.
    issue(52'd100, 26'd7);
    wait_done(0, 1'b1, cyc);
    check_result("t3", cyc, 27, 26'd14, 26'd2, 1'b0, 1'b0);

    // Extra remainder case: 1000000 / 999 = 1001 r 1.
    issue(52'd1000000, 26'd999);
    wait_done(0, 1'b1, cyc);
    check_result("t3b", cyc, 27, 26'd1001, 26'd1, 1'b0, 1'b0);

    // 4: divide by zero, reported one clock after start.
    issue(52'd12345, 26'd0);
    wait_done(0, 1'b1, cyc);
    check_result("t4", cyc, 1, 26'h3FFFFFF, 26'd0, 1'b1, 1'b0);

    // Divide by zero wins even when the high half would also overflow.
    issue(52'hFFFFFFFFFFFFF, 26'd0);
    wait_done(0, 1'b1, cyc);
    check_result("t4b", cyc, 1, 26'h3FFFFFF, 26'd0, 1'b1, 1'b0);

    // 5: (5<<26) / 5 overflows, high half equals divisor.
    issue(52'h0000014000000, 26'd5);
    wait_done(0, 1'b1, cyc);
    check_result("t5", cyc, 1, 26'h3FFFFFF, 26'd0, 1'b0, 1'b1);

    // 6a: start pulsed mid-CALC with other operands is ignored.
    issue(52'd100, 26'd7);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dividend = 52'd3000;
    divisor  = 26'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t6_busy_mid", 64'(busy), 64'd1);
    check("t6_no_partial_quot", 64'(quotient), 64'h3FFFFFF);
    wait_done(7, 1'b1, cyc);
    check_result("t6", cyc, 27, 26'd14, 26'd2, 1'b0, 1'b0);

    // 6b: reset at iteration 10 aborts and clears all outputs.
    issue(52'd3000, 26'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_quot", 64'(quotient), 64'd0);
    check("t6_rst_rem", 64'(remainder), 64'd0);
    check("t6_rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(52'd100, 26'd7);
    wait_done(0, 1'b1, cyc);
    check_result("t6_after_rst", cyc, 27, 26'd14, 26'd2, 1'b0, 1'b0);

    // Back-to-back with start held: one op every W+2 clocks.
    issue(52'd3000, 26'd3);
    wait_done(0, 1'b0, cyc);
    check("b2b_first_latency", 64'(cyc), 64'd27);
    check("b2b_first_quot", 64'(quotient), 64'd1000);
    dividend = 52'd100;
    divisor  = 26'd7;
    wait_done(0, 1'b0, cyc);
    start = 1'b0;
    check("b2b_second_period", 64'(cyc), 64'd28);
    check_result("b2b_second", 28, 28, 26'd14, 26'd2, 1'b0, 1'b0);

    // Regression: products of multiplier operands divide back exactly.
    issue(52'd8369910, 26'd678);
    wait_done(0, 1'b1, cyc);
    check_result("reg_12345x678", cyc, 27, 26'd12345, 26'd0, 1'b0, 1'b0);
    issue(52'h0000003FFFFFF, 26'd1);
    wait_done(0, 1'b1, cyc);
    check_result("reg_max_x1", cyc, 27, 26'h3FFFFFF, 26'd0, 1'b0, 1'b0);
    issue(52'h0000003FFFFFF, 26'h3FFFFFF);
    wait_done(0, 1'b1, cyc);
    check_result("reg_1_xmax", cyc, 27, 26'd1, 26'd0, 1'b0, 1'b0);
    issue(52'h0000004000000, 26'd2);
    wait_done(0, 1'b1, cyc);
    check_result("reg_msb_x2", cyc, 27, 26'h2000000, 26'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
